// File: rtl/rf_stream_port.sv
// Register-file sequencing master: FILL streams words into r0..r7, DUMP streams r0..r7 out.
// Define RF_STREAM_CHKSUM_EN to add a trailing mod-2^WIDTH checksum beat to both directions.
module rf_stream_port #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [SEL_W-1:0] rf_read1regsel,
  output logic [SEL_W-1:0] rf_read2regsel,
  input  logic [WIDTH-1:0] rf_read1data,
  input  logic [WIDTH-1:0] rf_read2data,
  output logic [SEL_W-1:0] rf_writeregsel,
  output logic [WIDTH-1:0] rf_writedata,
  output logic             rf_write,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_FILL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             write_en;
  logic             last_beat;

`ifdef RF_STREAM_CHKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             chk_q, chk_d;
  logic             bad_q, bad_d;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    in_ready       = 1'b0;
    write_en       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    err            = start && (state_q != S_IDLE);
    rf_read1regsel = idx_q;
    rf_read2regsel = idx_q + SEL_W'(1);
`ifdef RF_STREAM_CHKSUM_EN
    sum_d          = sum_q;
    chk_d          = chk_q;
    bad_d          = bad_q;
    last_beat      = chk_q;
`else
    last_beat      = (idx_q == '1);
`endif

    case (state_q)
      S_IDLE: begin
        rf_read1regsel = '0;
        if (start) begin
          idx_d = '0;
`ifdef RF_STREAM_CHKSUM_EN
          chk_d = 1'b0;
          bad_d = 1'b0;
          sum_d = mode ? '0 : rf_read1data;
`endif
          if (mode) begin
            state_d = S_FILL;
          end else begin
            out_data_d  = rf_read1data;
            out_valid_d = 1'b1;
            state_d     = S_DUMP;
          end
        end
      end
      S_DUMP: begin
        busy = 1'b1;
        if (out_valid_q && out_ready) begin
          if (last_beat) begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end else if (idx_q == '1) begin
`ifdef RF_STREAM_CHKSUM_EN
            // r7 just left; the accumulated sum becomes the extra beat
            out_data_d = sum_q;
            chk_d      = 1'b1;
`endif
          end else begin
            out_data_d = rf_read2data;
            idx_d      = idx_q + SEL_W'(1);
`ifdef RF_STREAM_CHKSUM_EN
            sum_d      = sum_q + rf_read2data;
`endif
          end
        end
      end
      S_FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
`ifdef RF_STREAM_CHKSUM_EN
        if (chk_q) begin
          if (in_valid) begin
            bad_d   = (in_data != sum_q);
            state_d = S_DONE;
          end
        end else begin
`else
        begin
`endif
          write_en = in_valid;
          if (in_valid) begin
`ifdef RF_STREAM_CHKSUM_EN
            sum_d = sum_q + in_data;
            if (idx_q == '1) chk_d = 1'b1;
            else             idx_d = idx_q + SEL_W'(1);
`else
            if (idx_q == '1) state_d = S_DONE;
            else             idx_d   = idx_q + SEL_W'(1);
`endif
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
`ifdef RF_STREAM_CHKSUM_EN
        if (bad_q) err = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef RF_STREAM_CHKSUM_EN
      sum_q       <= '0;
      chk_q       <= 1'b0;
      bad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef RF_STREAM_CHKSUM_EN
      sum_q       <= sum_d;
      chk_q       <= chk_d;
      bad_q       <= bad_d;
`endif
    end
  end

  // Never write during a reset cycle, even if the FILL handshake is live.
  assign rf_write       = write_en && !rst;
  assign rf_writeregsel = idx_q;
  assign rf_writedata   = in_data;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

endmodule

// File: tb/tb_rf_stream_port.sv
// Bench for rf_stream_port: register-file model, stream scoreboard and directed FILL/DUMP scenarios.
// Build with RF_STREAM_CHKSUM_EN defined to exercise the checksum beat.
module tb_rf_stream_port;
  localparam int W = 16;
  localparam int S = 3;
`ifdef RF_STREAM_CHKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic         clk = 1'b0;
  logic         rst, start, mode, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, rf_write, busy, done, err;
  logic [W-1:0] out_data, rf_read1data, rf_read2data, rf_writedata;
  logic [S-1:0] rf_read1regsel, rf_read2regsel, rf_writeregsel;

  rf_stream_port #(.WIDTH(W), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .rf_read1regsel(rf_read1regsel), .rf_read2regsel(rf_read2regsel),
    .rf_read1data(rf_read1data), .rf_read2data(rf_read2data),
    .rf_writeregsel(rf_writeregsel), .rf_writedata(rf_writedata),
    .rf_write(rf_write), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // register file: combinational read, cleared by reset
  logic [W-1:0] rf_mem [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    end else if (rf_write) begin
      rf_mem[rf_writeregsel] <= rf_writedata;
    end
  end
  assign rf_read1data = rf_mem[rf_read1regsel];
  assign rf_read2data = rf_mem[rf_read2regsel];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: what the register file should hold, and the streams expected
  logic [W-1:0] golden [8];
  logic [W-1:0] exp_stream [NB];
  logic [W-1:0] fill_words [8];
  int           beat, wcnt;
  bit           dump_active = 0, fill_active = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fill_active && wcnt < 8 && in_valid) begin
        chk("fill_we", rf_write, 1);
        chk("fill_sel", rf_writeregsel, wcnt);
        chk("fill_data", rf_writedata, fill_words[wcnt]);
        wcnt++;
      end else begin
        chk("no_write", rf_write, 0);
      end
      if (dump_active && beat < NB) begin
        chk("dump_valid", out_valid, 1);
        if (out_valid) begin
          chk("dump_data", out_data, exp_stream[beat]);
          if (out_ready) beat++;
        end
      end else begin
        chk("no_valid", out_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] sum8(input logic [W-1:0] w [NB]);
    logic [W-1:0] s = '0;
    for (int i = 0; i < 8; i++) s = s + w[i];
    return s;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic do_fill(input logic [W-1:0] w [NB], input logic [7:0] vpat,
                         input int abort_after, input logic exp_err);
    int k, cyc;
    for (int i = 0; i < 8; i++) fill_words[i] = w[i];
    start = 1; mode = 1;
    tick();
    start = 0; wcnt = 0; fill_active = 1;
    k = 0; cyc = 0;
    while (k < NB && cyc < 200) begin
      in_valid = vpat[cyc % 8];
      in_data  = in_valid ? w[k] : 16'hBEEF;
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (k < 8) golden[k] = w[k];
        k++;
      end
      tick();
      cyc++;
      if (abort_after > 0 && k == abort_after) begin
        rst = 1; in_valid = 1; in_data = w[k];
        @(negedge clk);
        chk("rst_no_write", rf_write, 0);
        tick();
        rst = 0; in_valid = 0; fill_active = 0;
        for (int i = 0; i < 8; i++) golden[i] = '0;
        @(negedge clk);
        check_idle_zero("after_abort");
        tick();
        return;
      end
    end
    in_valid = 0;
    chk("fill_beats", k, NB);
    @(negedge clk);
    chk("fill_done", done, 1);
    chk("fill_done_err", err, exp_err);
    tick();
    fill_active = 0;
    @(negedge clk);
    chk("fill_done_once", done, 0);
    chk("fill_busy_after", busy, 0);
    tick();
  endtask

  task automatic do_dump(input logic [7:0] rpat, input int poke_cyc,
                         output logic [W-1:0] got [NB], output int cycles);
    int n, cyc;
    for (int i = 0; i < 8; i++) exp_stream[i] = golden[i];
`ifdef RF_STREAM_CHKSUM_EN
    exp_stream[8] = golden[0] + golden[1] + golden[2] + golden[3]
                  + golden[4] + golden[5] + golden[6] + golden[7];
`endif
    for (int i = 0; i < NB; i++) got[i] = 'x;
    start = 1; mode = 0;
    tick();
    start = 0; beat = 0; dump_active = 1;
    n = 0; cyc = 0;
    while (n < NB && cyc < 200) begin
      out_ready = rpat[cyc % 8];
      start     = (cyc == poke_cyc);
      @(negedge clk);
      if (cyc == 0) chk("dump_first_valid", out_valid, 1);
      chk("dump_err", err, (cyc == poke_cyc));
      if (out_valid && out_ready) begin
        got[n] = out_data;
        n++;
      end
      tick();
      cyc++;
    end
    start = 0; out_ready = 0;
    cycles = cyc;
    chk("dump_beats", n, NB);
    @(negedge clk);
    chk("dump_done", done, 1);
    chk("dump_done_err", err, 0);
    tick();
    dump_active = 0;
    @(negedge clk);
    chk("dump_done_once", done, 0);
    chk("dump_busy_after", busy, 0);
    tick();
  endtask

  logic [W-1:0] words [NB];
  logic [W-1:0] got [NB];
  int           cycles;

  initial begin
    rst = 1; start = 0; mode = 0; in_valid = 0; in_data = '0; out_ready = 0;
    for (int i = 0; i < 8; i++) golden[i] = '0;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    check_idle_zero("reset");
    tick();

    // fill 0x1000+k back to back
    for (int i = 0; i < 8; i++) words[i] = 16'h1000 + W'(i);
`ifdef RF_STREAM_CHKSUM_EN
    words[8] = sum8(words);
`endif
    do_fill(words, 8'hFF, 0, 1'b0);

    do_dump(8'hFF, -1, got, cycles);
    chk("dump_cycles_full_rate", cycles, NB);
    chk("lit_first_word", got[0], 16'h1000);
    chk("lit_last_word", got[7], 16'h1007);
`ifdef RF_STREAM_CHKSUM_EN
    chk("lit_checksum", got[8], 16'h801C);
`endif

    // sink stalls with pattern 1,0,0,1,...
    do_dump(8'h99, -1, got, cycles);
    chk("lit_stalled_word3", got[3], 16'h1003);
    chk("lit_stalled_word7", got[7], 16'h1007);

    // fill with source gaps 1,0,1,1,0,...
    for (int i = 0; i < 8; i++) words[i] = 16'hC000 + W'(i) * 16'h0111;
`ifdef RF_STREAM_CHKSUM_EN
    words[8] = sum8(words);
`endif
    do_fill(words, 8'h6D, 0, 1'b0);
    do_dump(8'hFF, -1, got, cycles);
    chk("lit_gap_word5", got[5], 16'hC555);

    // start while busy on the 3rd dump beat
    do_dump(8'hFF, 2, got, cycles);
    chk("lit_poke_word2", got[2], 16'hC222);

    // abort a fill after 4 writes, then dump the cleared file
    for (int i = 0; i < 8; i++) words[i] = 16'h2000 + W'(i);
`ifdef RF_STREAM_CHKSUM_EN
    words[8] = sum8(words);
`endif
    do_fill(words, 8'hFF, 4, 1'b0);
    do_dump(8'hFF, -1, got, cycles);
    chk("lit_cleared_word0", got[0], 16'h0000);
    chk("lit_cleared_word3", got[3], 16'h0000);

`ifdef RF_STREAM_CHKSUM_EN
    // wrong checksum beat
    for (int i = 0; i < 8; i++) words[i] = 16'h1000 + W'(i);
    words[8] = 16'h0000;
    do_fill(words, 8'hFF, 0, 1'b1);
    do_dump(8'hFF, -1, got, cycles);
    chk("lit_bad_chk_still_written", got[6], 16'h1006);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_stream_port.md
Name: rf_stream_port

Overview:
- Sequencing master for the 8-entry x 16-bit register file. It is the only driver of the register file's read-select and write ports.
- FILL mode takes a valid/ready word stream and writes it into r0..r7 in order.
- DUMP mode reads r0..r7 through both read ports and sends them out as a valid/ready word stream.
- Used for register-file load/save, debug dump and bench preload.

Parameters:
- WIDTH, 16, data word width; must match the register file.
- SEL_W, 3, register select width; NREGS = 2**SEL_W = 8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- mode  in  1  0 = DUMP, 1 = FILL; sampled with start
- in_valid  in  1  FILL stream word valid
- in_data  in  WIDTH  FILL stream word
- in_ready  out  1  FILL stream accept
- out_valid  out  1  DUMP stream word valid
- out_data  out  WIDTH  DUMP stream word (registered)
- out_ready  in  1  DUMP stream sink ready
- rf_read1regsel  out  SEL_W  to register file read port 1
- rf_read2regsel  out  SEL_W  to register file read port 2
- rf_read1data  in  WIDTH  from register file (combinational read)
- rf_read2data  in  WIDTH  from register file (combinational read)
- rf_writeregsel  out  SEL_W  to register file
- rf_writedata  out  WIDTH  to register file
- rf_write  out  1  register file write enable
- busy  out  1  high in DUMP or FILL
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset state: IDLE, idx=0. out_valid, out_data, done, err, busy, in_ready all 0.
- rf_write is gated with !rst, so no write can occur during a reset cycle.
- States: IDLE, DUMP, FILL, DONE.
- IDLE: rf_read1regsel=0.
  - start && !mode: capture out_data <= rf_read1data (r0), out_valid <= 1, idx <= 0, go to DUMP.
  - start && mode: idx <= 0, go to FILL.
- DUMP:
  - Selects: rf_read1regsel=idx; rf_read2regsel=idx+1 (wraps mod 8).
  - out_data holds steady while out_valid && !out_ready.
  - On handshake (out_valid && out_ready):
    - idx==7: out_valid <= 0, go to DONE.
    - Otherwise: out_data <= rf_read2data, idx <= idx+1.
  - Words appear in order r0..r7. First out_valid is 1 cycle after start. With out_ready held high, the 8 beats occupy 8 consecutive cycles.
- FILL:
  - in_ready=1.
  - rf_write = in_valid (combinational), rf_writeregsel=idx, rf_writedata=in_data.
  - Each handshake writes r[idx] at that clock edge.
  - idx==7 on handshake: go to DONE; otherwise idx <= idx+1.
  - in_valid low: no write, state and idx hold.
- DONE: done=1 for exactly one cycle, then IDLE.
- In every state except FILL, in_ready=0 and rf_write=0.
- busy=1 in DUMP and FILL only.
- start while not in IDLE: ignored; err pulses 1 cycle; the running operation is unaffected.
- start in the DONE cycle counts as "not IDLE": it is ignored and sets err.
- Reset mid-operation aborts immediately. The partial FILL is not rolled back; the register file's own reset clears it anyway.
- The register file is not written during DUMP, so read-after-write hazards cannot occur.

Optional Feature:
- Macro: RF_STREAM_CHKSUM_EN.
- When defined, DUMP appends a 9th beat: the 16-bit sum, mod 2^16, of r0..r7. The sum is accumulated as each word is loaded into out_data. DONE follows the 9th handshake.
- When defined, FILL expects a 9th in-beat, which is not written to the register file.
  - The beat is compared against the mod-2^16 sum of the 8 accepted words.
  - Mismatch: err pulses in the DONE cycle.
  - Either way, done pulses.
- When undefined: 8 beats per operation, no accumulator, and err only reports start-while-busy.

Test Plan:
- Reset, FILL with words 0x1000+k (k=0..7), in_valid always high → rf_write high 8 consecutive cycles, regsel 0..7; done 1 cycle after the last write; busy low afterwards.
- Following DUMP with out_ready=1 → out_valid rises 1 cycle after start; out_data is 0x1000..0x1007 on 8 consecutive cycles; done pulses next cycle.
- DUMP with out_ready toggling 1,0,0,1,... → each word held stable while stalled; no word skipped or duplicated; order r0..r7.
- FILL with in_valid gaps (pattern 1,0,1,1,0,...) → writes only on in_valid cycles, idx advances only on handshake; final contents correct.
- start pulsed at the 3rd DUMP beat → err=1 for 1 cycle; dump completes unchanged.
- rst asserted after the 4th FILL write, then a new DUMP → no write during the reset cycle; outputs zero after reset; dumps all 0x0000.
- With RF_STREAM_CHKSUM_EN: DUMP after the 0x1000+k fill → 9th beat 0x801C. FILL with checksum beat 0x0000 → err pulses with done.
